floor_access_ctrl: RTL and testbench

//  Parametrised access controller for a multi-floor car park; successor of the fixed 12-user / 2-floor ID logic.

---
 rtl/floor_pkg.sv | 57 +++++
 rtl/floor_occ_bank.sv | 62 ++++++
 rtl/floor_access_ctrl.sv | 261 ++++++++++++++++++++++++++
 tb/tb_floor_access_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/floor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : floor_pkg
// Purpose  : Shared opcodes, response codes, ID prefix, ID class type and
//            postfix helpers for the car-park access controller.
// Revision : 1.0  initial release
// ============================================================================
package floor_pkg;

   // Request opcodes
   localparam logic [1:0] OP_ENTER      = 2'd0;
   localparam logic [1:0] OP_EXIT       = 2'd1;
   localparam logic [1:0] OP_RESTRICT   = 2'd2;
   localparam logic [1:0] OP_UNRESTRICT = 2'd3;

   // Response codes
   localparam logic [3:0] RSP_OK_CHOSEN      = 4'd0;
   localparam logic [3:0] RSP_OK_ALT         = 4'd1;
   localparam logic [3:0] RSP_OK_EXIT        = 4'd2;
   localparam logic [3:0] RSP_ERR_UNKNOWN    = 4'd3;
   localparam logic [3:0] RSP_ERR_STATE      = 4'd4;
   localparam logic [3:0] RSP_ERR_RESTRICTED = 4'd5;
   localparam logic [3:0] RSP_ERR_FULL       = 4'd6;
   localparam logic [3:0] RSP_ERR_NOT_ADMIN  = 4'd7;
   localparam logic [3:0] RSP_ERR_FLOOR      = 4'd8;
   localparam logic [3:0] RSP_OK_ADMIN       = 4'd9;

   // Upper 20 bits shared by every valid ID
   localparam logic [19:0] ID_PREFIX = 20'h20230;

   // Which slice of the ID table an entry belongs to
   typedef enum logic [1:0] {
      CLS_NONE  = 2'd0,
      CLS_USER  = 2'd1,
      CLS_SPEC  = 2'd2,
      CLS_ADMIN = 2'd3
   } id_class_t;

   // Normal user k carries the BCD encoding of 10+k
   function automatic logic [7:0] user_postfix(input int k);
      int v;
      v = 10 + k;
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   // Special user k carries k
   function automatic logic [7:0] special_postfix(input int k);
      return 8'(k);
   endfunction

   // Admin k follows directly after the special users
   function automatic logic [7:0] admin_postfix(input int k, input int n_special);
      return 8'(n_special + k);
   endfunction

endpackage
`default_nettype wire

// File: rtl/floor_occ_bank.sv
`default_nettype none
// ============================================================================
// Module   : floor_occ_bank
// Purpose  : Occupancy counters for every normal floor plus the floor-0
//            special zone, driven by one shared inc/dec port.
// Revision : 1.0  initial release
// ============================================================================
module floor_occ_bank #(
   parameter int N_FLOORS = 2,
   parameter int CAP_NORM = 5,
   parameter int CAP_SPEC = 2,
   parameter int FLR_W    = 1,
   parameter int CNT_W    = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      inc,
   input  logic                      dec,
   input  logic [FLR_W-1:0]          flr_sel,
   input  logic                      spec_sel,
   output logic [N_FLOORS*CNT_W-1:0] occ_norm,
   output logic [CNT_W-1:0]          occ_spec,
   output logic [N_FLOORS-1:0]       flr_full,
   output logic                      spec_full
);

   for (genvar f = 0; f < N_FLOORS; f++) begin : g_floor
      logic [CNT_W-1:0] r_cnt;
      logic             w_sel;

      assign w_sel = !spec_sel && (flr_sel == FLR_W'(f));

      // Saturating up/down counter for normal floor f
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_cnt <= '0;
         end else if (inc && w_sel && !flr_full[f]) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end else if (dec && w_sel && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
      end

      assign occ_norm[f*CNT_W +: CNT_W] = r_cnt;
      assign flr_full[f]                = (r_cnt == CNT_W'(CAP_NORM));
   end

   // Saturating up/down counter for the special zone
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ_spec <= '0;
      end else if (inc && spec_sel && !spec_full) begin
         occ_spec <= occ_spec + CNT_W'(1);
      end else if (dec && spec_sel && (occ_spec != '0)) begin
         occ_spec <= occ_spec - CNT_W'(1);
      end
   end

   assign spec_full = (occ_spec == CNT_W'(CAP_SPEC));

endmodule
`default_nettype wire

// File: rtl/floor_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : floor_access_ctrl
// Purpose  : Multi-floor car-park access controller. Sequential ID table
//            scan, wrap-around floor allocation, occupancy tracking and a
//            coded response on a valid/ready handshake.
// Revision : 1.0  initial release
// ============================================================================
module floor_access_ctrl #(
   parameter int          N_USERS   = 12,
   parameter int          N_SPECIAL = 2,
   parameter int          N_ADMIN   = 2,
   parameter int          N_FLOORS  = 2,
   parameter int          CAP_NORM  = 5,
   parameter int          CAP_SPEC  = 2,
   parameter logic [19:0] ID_PREFIX = floor_pkg::ID_PREFIX,
   localparam int         FLR_W     = $clog2(N_FLOORS),
   localparam int         CNT_W     = $clog2(((CAP_NORM > CAP_SPEC) ? CAP_NORM : CAP_SPEC) + 1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [1:0]                req_op,
   input  logic [27:0]               req_id,
   input  logic [FLR_W-1:0]          req_flr,
   input  logic [27:0]               req_admin_id,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [3:0]                rsp_code,
   output logic [FLR_W-1:0]          rsp_flr,
   output logic [N_FLOORS*CNT_W-1:0] occ_norm,
   output logic [CNT_W-1:0]          occ_spec,
   output logic [N_FLOORS-1:0]       flr_full,
   output logic                      spec_full
);
   import floor_pkg::*;

   localparam int N_SCAN = N_USERS + N_SPECIAL + N_ADMIN;
   localparam int SCAN_W = (N_SCAN > 1) ? $clog2(N_SCAN) : 1;
   // Tables are padded to a power of two so the scan index addresses them exactly
   localparam int TAB_N  = 1 << SCAN_W;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SCAN   = 3'd1;
   localparam logic [2:0] S_ALLOC  = 3'd2;
   localparam logic [2:0] S_COMMIT = 3'd3;
   localparam logic [2:0] S_RESP   = 3'd4;

   logic [2:0]                       r_state;
   logic [1:0]                       r_op;
   logic [27:0]                      r_id;
   logic [FLR_W-1:0]                 r_flr;
   logic [27:0]                      r_admin_id;
   logic [SCAN_W-1:0]                r_scan_idx;
   id_class_t                        r_hit_cls;
   logic [SCAN_W-1:0]                r_hit_idx;
   logic                             r_admin_ok;
   logic [FLR_W-1:0]                 r_try_flr;
   logic [FLR_W-1:0]                 r_alloc_cnt;
   logic                             r_alloc_ok;
   logic                             r_alloc_alt;
   logic [FLR_W-1:0]                 r_grant_flr;
   logic [TAB_N-1:0]                 r_inside;
   logic [TAB_N-1:0]                 r_restr;
   logic [TAB_N-1:0][FLR_W-1:0]      r_flr_tab;

   // Constant ID table: class and postfix per scan index
   id_class_t                        cls_tab [TAB_N];
   logic [7:0]                       pf_tab  [TAB_N];

   for (genvar g = 0; g < TAB_N; g++) begin : g_tab
      if (g < N_USERS) begin : g_user
         assign cls_tab[g] = CLS_USER;
         assign pf_tab[g]  = user_postfix(g);
      end else if (g < N_USERS + N_SPECIAL) begin : g_spec
         assign cls_tab[g] = CLS_SPEC;
         assign pf_tab[g]  = special_postfix(g - N_USERS);
      end else if (g < N_SCAN) begin : g_admin
         assign cls_tab[g] = CLS_ADMIN;
         assign pf_tab[g]  = admin_postfix(g - N_USERS - N_SPECIAL, N_SPECIAL);
      end else begin : g_pad
         assign cls_tab[g] = CLS_NONE;
         assign pf_tab[g]  = 8'h00;
      end
   end

   // Scan-cycle comparison against the current table entry (prefix included)
   id_class_t         w_cur_cls;
   logic [27:0]       w_cur_id;
   logic              w_id_hit;
   logic              w_adm_hit;
   id_class_t         w_cls_nxt;
   logic [SCAN_W-1:0] w_idx_nxt;
   logic              w_flr_ok;
   logic              w_need_alloc;

   assign w_cur_cls    = cls_tab[r_scan_idx];
   assign w_cur_id     = {ID_PREFIX, pf_tab[r_scan_idx]};
   assign w_id_hit     = (w_cur_cls != CLS_NONE) && (r_id == w_cur_id);
   assign w_adm_hit    = (w_cur_cls == CLS_ADMIN) && (r_admin_id == w_cur_id);
   assign w_cls_nxt    = w_id_hit ? w_cur_cls : r_hit_cls;
   assign w_idx_nxt    = w_id_hit ? r_scan_idx : r_hit_idx;
   assign w_flr_ok     = ({1'b0, r_flr} < (FLR_W+1)'(N_FLOORS));
   // Allocation only runs when nothing ahead of ERR_FULL can already reject the ENTER
   assign w_need_alloc = (r_op == OP_ENTER) && (w_cls_nxt == CLS_USER) && w_flr_ok
                         && !r_inside[w_idx_nxt] && !r_restr[w_idx_nxt];

   logic w_is_enter, w_is_exit, w_is_adm_op, w_inside, w_restr;
   assign w_is_enter  = (r_op == OP_ENTER);
   assign w_is_exit   = (r_op == OP_EXIT);
   assign w_is_adm_op = (r_op == OP_RESTRICT) || (r_op == OP_UNRESTRICT);
   assign w_inside    = r_inside[r_hit_idx];
   assign w_restr     = r_restr[r_hit_idx];

   logic [3:0]       w_code;
   logic [FLR_W-1:0] w_rsp_flr;

   // Prioritised decision for the latched request
   always_comb begin
      w_code    = RSP_OK_ADMIN;
      w_rsp_flr = '0;
      if ((r_hit_cls == CLS_NONE) || (!w_is_adm_op && (r_hit_cls == CLS_ADMIN))) begin
         w_code = RSP_ERR_UNKNOWN;
      end else if (w_is_adm_op && (!r_admin_ok || (r_hit_cls != CLS_USER))) begin
         w_code = RSP_ERR_NOT_ADMIN;
      end else if (w_is_enter && (r_hit_cls == CLS_USER) && !w_flr_ok) begin
         w_code = RSP_ERR_FLOOR;
      end else if ((w_is_enter && w_inside) || (w_is_exit && !w_inside)) begin
         w_code = RSP_ERR_STATE;
      end else if (w_is_enter && (r_hit_cls == CLS_USER) && w_restr) begin
         w_code = RSP_ERR_RESTRICTED;
      end else if (w_is_enter && (((r_hit_cls == CLS_USER) && !r_alloc_ok) ||
                                  ((r_hit_cls == CLS_SPEC) && spec_full))) begin
         w_code = RSP_ERR_FULL;
      end else if (w_is_enter) begin
         w_code = ((r_hit_cls == CLS_USER) && r_alloc_alt) ? RSP_OK_ALT : RSP_OK_CHOSEN;
         if (r_hit_cls == CLS_USER) w_rsp_flr = r_grant_flr;
      end else if (w_is_exit) begin
         w_code = RSP_OK_EXIT;
         if (r_hit_cls == CLS_USER) w_rsp_flr = r_flr_tab[r_hit_idx];
      end
   end

   logic             w_inc, w_dec;
   logic [FLR_W-1:0] w_bank_flr;
   logic             w_bank_spec;

   assign w_inc       = (r_state == S_COMMIT) && ((w_code == RSP_OK_CHOSEN) || (w_code == RSP_OK_ALT));
   assign w_dec       = (r_state == S_COMMIT) && (w_code == RSP_OK_EXIT);
   assign w_bank_flr  = w_is_enter ? r_grant_flr : r_flr_tab[r_hit_idx];
   assign w_bank_spec = (r_hit_cls == CLS_SPEC);

   floor_occ_bank #(
      .N_FLOORS (N_FLOORS),
      .CAP_NORM (CAP_NORM),
      .CAP_SPEC (CAP_SPEC),
      .FLR_W    (FLR_W),
      .CNT_W    (CNT_W)
   ) u_occ (
      .clk       (clk),
      .rst       (rst),
      .inc       (w_inc),
      .dec       (w_dec),
      .flr_sel   (w_bank_flr),
      .spec_sel  (w_bank_spec),
      .occ_norm  (occ_norm),
      .occ_spec  (occ_spec),
      .flr_full  (flr_full),
      .spec_full (spec_full)
   );

   assign req_ready = (r_state == S_IDLE);
   assign rsp_valid = (r_state == S_RESP);

   // Request FSM, scan/allocation bookkeeping and table updates
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_op        <= '0;
         r_id        <= '0;
         r_flr       <= '0;
         r_admin_id  <= '0;
         r_scan_idx  <= '0;
         r_hit_cls   <= CLS_NONE;
         r_hit_idx   <= '0;
         r_admin_ok  <= 1'b0;
         r_try_flr   <= '0;
         r_alloc_cnt <= '0;
         r_alloc_ok  <= 1'b0;
         r_alloc_alt <= 1'b0;
         r_grant_flr <= '0;
         r_inside    <= '0;
         r_restr     <= '0;
         r_flr_tab   <= '0;
         rsp_code    <= '0;
         rsp_flr     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_op        <= req_op;
                  r_id        <= req_id;
                  r_flr       <= req_flr;
                  r_admin_id  <= req_admin_id;
                  r_scan_idx  <= '0;
                  r_hit_cls   <= CLS_NONE;
                  r_hit_idx   <= '0;
                  r_admin_ok  <= 1'b0;
                  r_alloc_ok  <= 1'b0;
                  r_alloc_alt <= 1'b0;
                  r_grant_flr <= '0;
                  r_state     <= S_SCAN;
               end
            end
            S_SCAN: begin
               r_hit_cls <= w_cls_nxt;
               r_hit_idx <= w_idx_nxt;
               if (w_adm_hit) r_admin_ok <= 1'b1;
               if (r_scan_idx == SCAN_W'(N_SCAN - 1)) begin
                  r_try_flr   <= r_flr;
                  r_alloc_cnt <= '0;
                  r_state     <= w_need_alloc ? S_ALLOC : S_COMMIT;
               end else begin
                  r_scan_idx <= r_scan_idx + 1'b1;
               end
            end
            S_ALLOC: begin
               if (!flr_full[r_try_flr]) begin
                  r_alloc_ok  <= 1'b1;
                  r_alloc_alt <= (r_alloc_cnt != '0);
                  r_grant_flr <= r_try_flr;
                  r_state     <= S_COMMIT;
               end else if (r_alloc_cnt == FLR_W'(N_FLOORS - 1)) begin
                  r_state <= S_COMMIT;
               end else begin
                  r_try_flr   <= (r_try_flr == FLR_W'(N_FLOORS - 1)) ? '0 : r_try_flr + 1'b1;
                  r_alloc_cnt <= r_alloc_cnt + 1'b1;
               end
            end
            S_COMMIT: begin
               rsp_code <= w_code;
               rsp_flr  <= w_rsp_flr;
               if (w_inc) begin
                  r_inside[r_hit_idx] <= 1'b1;
                  if (r_hit_cls == CLS_USER) r_flr_tab[r_hit_idx] <= r_grant_flr;
               end
               if (w_dec) r_inside[r_hit_idx] <= 1'b0;
               if (w_code == RSP_OK_ADMIN) r_restr[r_hit_idx] <= (r_op == OP_RESTRICT);
               r_state <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_floor_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_floor_access_ctrl
// Purpose  : Directed self-checking bench for floor_access_ctrl.
// Revision : 1.0  initial release
// ============================================================================
module tb_floor_access_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_op = 2'd0;
   logic [27:0] req_id = '0;
   logic [0:0]  req_flr = '0;
   logic [27:0] req_admin_id = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [3:0]  rsp_code;
   logic [0:0]  rsp_flr;
   logic [5:0]  occ_norm;
   logic [2:0]  occ_spec;
   logic [1:0]  flr_full;
   logic        spec_full;

   int checks   = 0;
   int failures = 0;
   int lat      = 0;

   floor_access_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_op       (req_op),
      .req_id       (req_id),
      .req_flr      (req_flr),
      .req_admin_id (req_admin_id),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_code     (rsp_code),
      .rsp_flr      (rsp_flr),
      .occ_norm     (occ_norm),
      .occ_spec     (occ_spec),
      .flr_full     (flr_full),
      .spec_full    (spec_full)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One full request/response transaction; lat counts edges from accept to rsp_valid
   task automatic xact(input string tag, input logic [1:0] op, input logic [27:0] id,
                       input logic fl, input logic [27:0] adm,
                       input logic [3:0] exp_code, input logic exp_flr);
      int n;
      @(negedge clk);
      req_valid = 1'b1; req_op = op; req_id = id; req_flr = fl; req_admin_id = adm;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1; n = 0;
      while (!rsp_valid && n < 100) begin
         @(posedge clk); #1;
         lat++; n++;
      end
      chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_code"}, 32'(rsp_code), 32'(exp_code));
      chk({tag, "_flr"}, 32'(rsp_flr), 32'(exp_flr));
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
   endtask

   initial begin
      logic ok;
      logic [27:0] ids [4];
      int n;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_code",  32'(rsp_code),  32'd0);
      chk("rst_occ_norm",  32'(occ_norm),  32'd0);
      chk("rst_occ_spec",  32'(occ_spec),  32'd0);
      chk("rst_full",      32'({flr_full, spec_full}), 32'd0);

      // 1: first ENTER on chosen floor, 16 scan + 1 alloc + 2
      xact("t1_enter", 2'd0, 28'h2023010, 1'b0, 28'h0, 4'd0, 1'b0);
      chk("t1_lat", 32'(lat), 32'd19);
      chk("t1_occ", 32'(occ_norm), 32'h01);

      // 2: fill floor 1, then alternative floor
      xact("t2_u17", 2'd0, 28'h2023017, 1'b1, 28'h0, 4'd0, 1'b1);
      xact("t2_u18", 2'd0, 28'h2023018, 1'b1, 28'h0, 4'd0, 1'b1);
      xact("t2_u19", 2'd0, 28'h2023019, 1'b1, 28'h0, 4'd0, 1'b1);
      xact("t2_u20", 2'd0, 28'h2023020, 1'b1, 28'h0, 4'd0, 1'b1);
      xact("t2_u21", 2'd0, 28'h2023021, 1'b1, 28'h0, 4'd0, 1'b1);
      chk("t2_occ_full1", 32'(occ_norm), 32'h29);
      chk("t2_flr_full", 32'(flr_full), 32'd2);
      xact("t2_alt", 2'd0, 28'h2023016, 1'b1, 28'h0, 4'd1, 1'b0);
      chk("t2_alt_lat", 32'(lat), 32'd20);
      chk("t2_occ_alt", 32'(occ_norm), 32'h2A);

      // 3: state errors and exits
      xact("t3_reenter", 2'd0, 28'h2023010, 1'b0, 28'h0, 4'd4, 1'b0);
      chk("t3_reenter_lat", 32'(lat), 32'd18);
      xact("t3_exit0", 2'd1, 28'h2023010, 1'b0, 28'h0, 4'd2, 1'b0);
      chk("t3_occ_exit0", 32'(occ_norm), 32'h29);
      xact("t3_exit1", 2'd1, 28'h2023017, 1'b0, 28'h0, 4'd2, 1'b1);
      chk("t3_occ_exit1", 32'(occ_norm), 32'h21);
      chk("t3_flr_full", 32'(flr_full), 32'd0);
      xact("t3_reexit", 2'd1, 28'h2023017, 1'b0, 28'h0, 4'd4, 1'b0);

      // 4: restriction handling
      xact("t4_restrict", 2'd2, 28'h2023012, 1'b0, 28'h2023002, 4'd9, 1'b0);
      xact("t4_enter_restr", 2'd0, 28'h2023012, 1'b0, 28'h0, 4'd5, 1'b0);
      chk("t4_restr_lat", 32'(lat), 32'd18);
      xact("t4_bad_admin", 2'd2, 28'h2023012, 1'b0, 28'h2023099, 4'd7, 1'b0);
      xact("t4_restr_spec", 2'd2, 28'h2023000, 1'b0, 28'h2023002, 4'd7, 1'b0);
      xact("t4_admin_enter", 2'd0, 28'h2023002, 1'b0, 28'h0, 4'd3, 1'b0);
      xact("t4_unrestrict", 2'd3, 28'h2023012, 1'b0, 28'h2023003, 4'd9, 1'b0);
      xact("t4_enter_ok", 2'd0, 28'h2023012, 1'b1, 28'h0, 4'd0, 1'b1);
      xact("t4_restr_inside", 2'd2, 28'h2023012, 1'b0, 28'h2023003, 4'd9, 1'b0);
      xact("t4_exit_restr", 2'd1, 28'h2023012, 1'b0, 28'h0, 4'd2, 1'b1);
      chk("t4_occ", 32'(occ_norm), 32'h21);

      // 5: special zone and unknown ID
      xact("t5_spec0", 2'd0, 28'h2023000, 1'b0, 28'h0, 4'd0, 1'b0);
      chk("t5_occ_spec1", 32'(occ_spec), 32'd1);
      xact("t5_spec1", 2'd0, 28'h2023001, 1'b1, 28'h0, 4'd0, 1'b0);
      chk("t5_occ_spec2", 32'(occ_spec), 32'd2);
      chk("t5_spec_full", 32'(spec_full), 32'd1);
      chk("t5_occ_norm", 32'(occ_norm), 32'h21);
      xact("t5_spec_again", 2'd0, 28'h2023000, 1'b0, 28'h0, 4'd4, 1'b0);
      xact("t5_unknown", 2'd0, 28'h2024010, 1'b0, 28'h0, 4'd3, 1'b0);

      // Fill floor 0, wrap to floor 1, then everything full
      ids[0] = 28'h2023011; ids[1] = 28'h2023013; ids[2] = 28'h2023014; ids[3] = 28'h2023015;
      for (int i = 0; i < 4; i++) begin
         xact("fill0", 2'd0, ids[i], 1'b0, 28'h0, 4'd0, 1'b0);
      end
      chk("fill0_occ", 32'(occ_norm), 32'h25);
      chk("fill0_full", 32'(flr_full), 32'd1);
      xact("wrap_alt", 2'd0, 28'h2023017, 1'b0, 28'h0, 4'd1, 1'b1);
      chk("wrap_occ", 32'(occ_norm), 32'h2D);
      xact("all_full", 2'd0, 28'h2023010, 1'b1, 28'h0, 4'd6, 1'b0);
      chk("all_full_lat", 32'(lat), 32'd20);
      chk("all_full_occ", 32'(occ_norm), 32'h2D);

      // 6: response held while rsp_ready stays low
      @(negedge clk);
      req_valid = 1'b1; req_op = 2'd0; req_id = 28'h2023010; req_flr = 1'b0; req_admin_id = '0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (!(rsp_valid === 1'b1 && rsp_code === 4'd6 && req_ready === 1'b0)) ok = 1'b0;
      end
      chk("hold_stable", 32'(ok), 32'd1);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("hold_released", 32'(req_ready), 32'd1);

      // Asynchronous reset during SCAN
      @(negedge clk);
      req_valid = 1'b1; req_op = 2'd0; req_id = 28'h2023010; req_flr = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_occ_norm", 32'(occ_norm), 32'd0);
      chk("arst_occ_spec", 32'(occ_spec), 32'd0);
      chk("arst_full", 32'({flr_full, spec_full}), 32'd0);
      chk("arst_req_ready", 32'(req_ready), 32'd1);
      chk("arst_rsp_code", 32'(rsp_code), 32'd0);
      @(negedge clk); rst = 1'b0;
      ok = 1'b1;
      for (int i = 0; i < 25; i++) begin
         @(posedge clk); #1;
         if (rsp_valid !== 1'b0) ok = 1'b0;
      end
      chk("arst_no_rsp", 32'(ok), 32'd1);

      // Tables cleared: restricted user and special user enter again
      xact("post_rst_u12", 2'd0, 28'h2023012, 1'b0, 28'h0, 4'd0, 1'b0);
      xact("post_rst_s0", 2'd0, 28'h2023000, 1'b0, 28'h0, 4'd0, 1'b0);
      chk("post_rst_occ", 32'(occ_norm), 32'h01);
      chk("post_rst_spec", 32'(occ_spec), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
